// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB-first, one bit per clock.
// The carry lives in a flop between bits; the result is published only on completion.

// Half adder used as the building block of the full-adder cell.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// Full adder built from two half adders; the only adder logic in the design.
module fa_using_ha (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   logic s1;
   logic c1;
   logic c2;

   half_adder ha0 (
      .a     (a),
      .b     (b),
      .sum   (s1),
      .carry (c1)
   );

   half_adder ha1 (
      .a     (s1),
      .b     (c_in),
      .sum   (sum),
      .carry (c2)
   );

   assign c_out = c1 | c2;

endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   // Counter needs at least one bit even when WIDTH is 1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_sum;
   logic             fa_cout;
   logic             accept;
   logic             last;

   fa_using_ha fa (
      .a     (op_a[0]),
      .b     (op_b[0]),
      .c_in  (carry),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next = fa_sum;
      end else begin : g_res_wn
         assign res_next = {fa_sum, res[WIDTH-1:1]};
      end
   endgenerate

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (state == ADD) && (count == LAST);

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs; DONE lasts exactly one cycle.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ADD;
            end
         end
         ADD: begin
            busy = 1'b1;
            if (count == LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? ADD : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand shifting, carry chaining and result publication on the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a  <= '0;
         op_b  <= '0;
         res   <= '0;
         carry <= 1'b0;
         count <= '0;
         sum   <= '0;
         c_out <= 1'b0;
      end else if (accept) begin
         op_a  <= a;
         op_b  <= b;
         carry <= c_in;
         count <= '0;
      end else if (state == ADD) begin
         op_a  <= op_a >> 1;
         op_b  <= op_b >> 1;
         res   <= res_next;
         carry <= fa_cout;
         count <= count + CW'(1);
         if (last) begin
            sum   <= res_next;
            c_out <= fa_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH 8, 3 and 1.
// Expected results and completion cycles are queued at issue; a monitor pops on done.

module tb_serial_adder_ctrl;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      int          cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   int         cyc;
   int         checks;
   int         errors;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start3;
   logic [2:0] a3;
   logic [2:0] b3;
   logic       cin3;
   logic       busy3;
   logic       done3;
   logic [2:0] sum3;
   logic       cout3;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;

   exp_t q8[$];
   exp_t q3[$];
   exp_t q1[$];

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .c_in  (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .c_out (cout8)
   );

   serial_adder_ctrl #(.WIDTH(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start3),
      .a     (a3),
      .b     (b3),
      .c_in  (cin3),
      .busy  (busy3),
      .done  (done3),
      .sum   (sum3),
      .c_out (cout3)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .c_in  (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .c_out (cout1)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to timestamp issue and completion.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Hard stop in case something never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act_sum, input logic act_cout,
                              input int act_cyc, input exp_t e);
      checkValue({name, "_sum"}, act_sum, e.sum);
      checkValue({name, "_cout"}, {31'd0, act_cout}, {31'd0, e.cout});
      checkValue({name, "_latency_cycle"}, act_cyc, e.cyc);
   endtask

   task automatic unexpectedDone(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got done pulse, expected none", name);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (done8) begin
            if (q8.size() == 0) unexpectedDone("w8_done");
            else begin
               e = q8.pop_front();
               checkOutput("w8", {24'd0, sum8}, cout8, cyc, e);
            end
         end
         if (done3) begin
            if (q3.size() == 0) unexpectedDone("w3_done");
            else begin
               e = q3.pop_front();
               checkOutput("w3", {29'd0, sum3}, cout3, cyc, e);
            end
         end
         if (done1) begin
            if (q1.size() == 0) unexpectedDone("w1_done");
            else begin
               e = q1.pop_front();
               checkOutput("w1", {31'd0, sum1}, cout1, cyc, e);
            end
         end
      end
   end

   // One-cycle start pulse on the 8-bit unit with its expected result queued.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                input logic [7:0] es, input logic ec);
      exp_t e;
      start8 = 1'b1;
      a8     = av;
      b8     = bv;
      cin8   = cv;
      e.sum  = {24'd0, es};
      e.cout = ec;
      e.cyc  = cyc + 1 + 8;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic waitDrain(input int limit);
      for (int i = 0; i < limit && (q8.size() + q3.size() + q1.size()) != 0; i++) begin
         @(negedge clk);
      end
      checkValue("drain_pending", q8.size() + q3.size() + q1.size(), 0);
      q8.delete();
      q3.delete();
      q1.delete();
   endtask

   // Directed sequence followed by exhaustive sweeps of the small widths.
   initial begin
      exp_t e;
      int   tot;
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst_n  = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

      repeat (2) @(negedge clk);
      checkValue("reset_busy", {31'd0, busy8}, 0);
      checkValue("reset_done", {31'd0, done8}, 0);
      checkValue("reset_sum", {24'd0, sum8}, 0);
      checkValue("reset_cout", {31'd0, cout8}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] basic add with busy window");
      applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checkValue("busy_during_add", {31'd0, busy8}, 1);
         @(negedge clk);
      end
      checkValue("busy_after_add", {31'd0, busy8}, 0);
      waitDrain(20);

      $display("[TB] back-to-back with start held");
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
      e.sum = 32'h02; e.cout = 1'b0; e.cyc = cyc + 9;
      q8.push_back(e);
      repeat (9) @(negedge clk);
      a8 = 8'h80; b8 = 8'h80;
      e.sum = 32'h00; e.cout = 1'b1; e.cyc = cyc + 9;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      waitDrain(30);

      $display("[TB] start and operand changes ignored during add");
      applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      @(negedge clk);
      a8 = 8'h77; b8 = 8'h21;
      @(negedge clk);
      start8 = 1'b0;
      waitDrain(20);
      repeat (4) @(negedge clk);

      $display("[TB] carry-out cases");
      applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      waitDrain(20);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      waitDrain(20);

      $display("[TB] asynchronous reset mid-add");
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkValue("rst_mid_busy", {31'd0, busy8}, 0);
      checkValue("rst_mid_done", {31'd0, done8}, 0);
      checkValue("rst_mid_sum", {24'd0, sum8}, 0);
      checkValue("rst_mid_cout", {31'd0, cout8}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checkValue("post_rst_busy", {31'd0, busy8}, 0);
      applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
      waitDrain(20);

      $display("[TB] exhaustive WIDTH=1");
      for (int av = 0; av < 2; av++) begin
         for (int bv = 0; bv < 2; bv++) begin
            for (int cv = 0; cv < 2; cv++) begin
               tot    = av + bv + cv;
               start1 = 1'b1;
               a1     = 1'(av);
               b1     = 1'(bv);
               cin1   = 1'(cv);
               e.sum  = 32'(tot % 2);
               e.cout = 1'(tot / 2);
               e.cyc  = cyc + 1 + 1;
               q1.push_back(e);
               @(negedge clk);
               start1 = 1'b0;
               repeat (3) @(negedge clk);
            end
         end
      end
      waitDrain(10);

      $display("[TB] exhaustive WIDTH=3");
      for (int av = 0; av < 8; av++) begin
         for (int bv = 0; bv < 8; bv++) begin
            for (int cv = 0; cv < 2; cv++) begin
               tot    = av + bv + cv;
               start3 = 1'b1;
               a3     = 3'(av);
               b3     = 3'(bv);
               cin3   = 1'(cv);
               e.sum  = 32'(tot % 8);
               e.cout = 1'(tot / 8);
               e.cyc  = cyc + 1 + 3;
               q3.push_back(e);
               @(negedge clk);
               start3 = 1'b0;
               repeat (5) @(negedge clk);
            end
         end
      end
      waitDrain(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
